// File: rtl/isa_pkg.sv
// isa_pkg: SuperSpeedCPU instruction field layout, opcodes and the shared encode helper.
package isa_pkg;
  localparam int INSTR_W  = 20;
  localparam int ADDR_W   = 10;
  localparam int OP_W     = 5;
  localparam int REG_W    = 4;
  localparam int IMM_BITS = 7;
  localparam logic [OP_W-1:0] OP_HALT     = 5'd0;
  localparam logic [OP_W-1:0] OP_ALU_LAST = 5'd10;
  localparam logic [OP_W-1:0] OP_LD       = 5'd11;
  localparam logic [OP_W-1:0] OP_ST       = 5'd12;
  localparam logic [OP_W-1:0] OP_JUMP     = 5'd13;
  localparam logic [OP_W-1:0] OP_PUSH     = 5'd14;
  localparam logic [OP_W-1:0] OP_POP      = 5'd15;
  localparam int DR_LSB    = 5;
  localparam int SR1_LSB   = 9;
  localparam int SR2_LSB   = 13;
  localparam int IMM_LSB   = 13;
  localparam int MADDR_LSB = 9;
  localparam int JADDR_LSB = 5;
  localparam int SRC_LSB   = 5;
  typedef enum logic [2:0] {S_IDLE, S_ACCEPT, S_WRITE, S_DONE, S_ERROR} state_e;
  function automatic logic is_iform(input logic [OP_W-1:0] op);
    return op != OP_HALT && op <= OP_ALU_LAST && !op[0];
  endfunction
  // The 20-bit immediate fits when every bit above the sign bit matches it.
  function automatic logic imm_fits(input logic [INSTR_W-1:0] imm);
    return (&imm[INSTR_W-1:IMM_BITS-1]) || !(|imm[INSTR_W-1:IMM_BITS-1]);
  endfunction
  function automatic logic [INSTR_W-1:0] encode(
    input logic [OP_W-1:0] op,
    input logic [REG_W-1:0] dr,
    input logic [REG_W-1:0] sr1,
    input logic [REG_W-1:0] sr2,
    input logic [INSTR_W-1:0] imm,
    input logic [ADDR_W-1:0] addr
  );
    logic [INSTR_W-1:0] w;
    w = INSTR_W'(op);
    if (op == OP_HALT || op > OP_POP) w = '0;
    else if (op <= OP_ALU_LAST) begin
      w[DR_LSB +: REG_W]  = dr;
      w[SR1_LSB +: REG_W] = sr1;
      if (op[0]) w[SR2_LSB +: REG_W] = sr2;
      else w[IMM_LSB +: IMM_BITS] = imm[IMM_BITS-1:0];
    end
    else if (op == OP_LD) begin
      w[DR_LSB +: REG_W]     = dr;
      w[MADDR_LSB +: ADDR_W] = addr;
    end
    else if (op == OP_ST) begin
      w[SRC_LSB +: REG_W]    = sr1;
      w[MADDR_LSB +: ADDR_W] = addr;
    end
    else if (op == OP_JUMP) w[JADDR_LSB +: ADDR_W] = addr;
    else if (op == OP_PUSH) w[SRC_LSB +: REG_W] = sr1;
    else w[DR_LSB +: REG_W] = dr;
    return w;
  endfunction
endpackage

// File: rtl/instruction_packer.sv
// instruction_packer: combinational field bundle to instruction word, flagging illegal bundles.
module instruction_packer
  import isa_pkg::*;
(
  input  logic [OP_W-1:0]    opcode_i,
  input  logic [REG_W-1:0]   dr_i,
  input  logic [REG_W-1:0]   sr1_i,
  input  logic [REG_W-1:0]   sr2_i,
  input  logic [INSTR_W-1:0] imm_i,
  input  logic [ADDR_W-1:0]  addr_i,
  output logic [INSTR_W-1:0] word_o,
  output logic               illegal_o
);
  assign word_o    = encode(opcode_i, dr_i, sr1_i, sr2_i, imm_i, addr_i);
  assign illegal_o = opcode_i > OP_POP || (is_iform(opcode_i) && !imm_fits(imm_i));
endmodule

// File: rtl/instruction_encoder.sv
// instruction_encoder: accepts field bundles, packs them and loads them into
// instruction memory at consecutive addresses until HALT, overflow or a bad bundle.
module instruction_encoder
  import isa_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    in_opcode,
  input  logic [REG_W-1:0]   in_dr,
  input  logic [REG_W-1:0]   in_sr1,
  input  logic [REG_W-1:0]   in_sr2,
  input  logic [INSTR_W-1:0] in_imm,
  input  logic [ADDR_W-1:0]  in_addr,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [ADDR_W:0]    count
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0] count_q, count_d;
  logic [INSTR_W-1:0] word_q, word_d, packed_w;
  logic halt_q, halt_d, illegal;
  instruction_packer u_packer (
    .opcode_i (in_opcode),
    .dr_i     (in_dr),
    .sr1_i    (in_sr1),
    .sr2_i    (in_sr2),
    .imm_i    (in_imm),
    .addr_i   (in_addr),
    .word_o   (packed_w),
    .illegal_o(illegal)
  );
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    word_d  = word_q;
    halt_d  = halt_q;
    case (state_q)
      S_ACCEPT: if (in_valid) begin
        state_d = illegal ? S_ERROR : S_WRITE;
        word_d  = illegal ? word_q : packed_w;
        halt_d  = in_opcode == OP_HALT;
      end
      // Address saturates at the top; the overflow is reported through ERROR.
      S_WRITE: begin
        count_d = count_q + 11'd1;
        addr_d  = &addr_q ? addr_q : addr_q + 10'd1;
        state_d = halt_q ? S_DONE : &addr_q ? S_ERROR : S_ACCEPT;
      end
      default: if (start) begin
        state_d = S_ACCEPT;
        addr_d  = base_addr;
        count_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      word_q  <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      word_q  <= word_d;
      halt_q  <= halt_d;
    end
  end
  // Reset gates the strobe so a write caught by reset never reaches memory.
  assign mem_we    = state_q == S_WRITE && !rst;
  assign in_ready  = state_q == S_ACCEPT;
  assign busy      = state_q == S_ACCEPT || state_q == S_WRITE;
  assign done      = state_q == S_DONE;
  assign error     = state_q == S_ERROR;
  assign mem_addr  = addr_q;
  assign mem_wdata = word_q;
  assign count     = count_q;
endmodule

// File: tb/tb_instruction_encoder.sv
// tb_instruction_encoder: directed vector table plus hand-written load sequences.
module tb_instruction_encoder;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic [9:0] base_addr = '0, in_addr = '0;
  logic [4:0] in_opcode = '0;
  logic [3:0] in_dr = '0, in_sr1 = '0, in_sr2 = '0;
  logic [19:0] in_imm = '0;
  logic in_ready, mem_we, busy, done, error;
  logic [9:0] mem_addr;
  logic [19:0] mem_wdata;
  logic [10:0] count;
  int checks = 0, errors = 0, nwr = 0, n0;
  logic [19:0] mem_m [1024];

  typedef struct {
    logic [4:0] op; logic [3:0] dr, sr1, sr2; logic [19:0] imm; logic [9:0] addr;
    logic [19:0] word; logic err;
  } vec_t;
  vec_t vt [16];

  instruction_encoder dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_dr(in_dr), .in_sr1(in_sr1), .in_sr2(in_sr2), .in_imm(in_imm),
    .in_addr(in_addr), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .error(error), .count(count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mem_we) begin
    mem_m[mem_addr] <= mem_wdata;
    nwr <= nwr + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst in_ready", in_ready, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst error", error, 0);
    chk("rst count", count, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_start(input logic [9:0] b);
    start = 1'b1;
    base_addr = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic set_fields(input vec_t v);
    in_opcode = v.op; in_dr = v.dr; in_sr1 = v.sr1; in_sr2 = v.sr2;
    in_imm = v.imm; in_addr = v.addr;
  endtask

  // Returns at the negedge following the accepting clock edge.
  task automatic send(input vec_t v);
    int k = 0;
    set_fields(v);
    in_valid = 1'b1;
    while (!in_ready && k < 8) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL handshake timeout: in_ready stayed 0, expected 1");
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  function automatic vec_t mk(input logic [4:0] op, input logic [3:0] dr, sr1, sr2,
                              input logic [19:0] imm, input logic [9:0] addr,
                              input logic [19:0] word, input logic err);
    vec_t v;
    v.op = op; v.dr = dr; v.sr1 = sr1; v.sr2 = sr2; v.imm = imm; v.addr = addr;
    v.word = word; v.err = err;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t add_v, halt_v, i_v, i64_v, ill_v, ld_v, pop_v;
    for (int i = 0; i < 1024; i++) mem_m[i] = 20'hABCDE;
    vt[0]  = mk(5'd1,  4'd2, 4'd3, 4'd4, 20'h00000, 10'h000, 20'h08641, 1'b0);
    vt[1]  = mk(5'd2,  4'd1, 4'd1, 4'd0, 20'hFFFFF, 10'h000, 20'hFE222, 1'b0);
    vt[2]  = mk(5'd2,  4'd1, 4'd1, 4'd0, 20'h00040, 10'h000, 20'h00000, 1'b1);
    vt[3]  = mk(5'd4,  4'hF, 4'd0, 4'd0, 20'h0003F, 10'h000, 20'h7E1E4, 1'b0);
    vt[4]  = mk(5'd10, 4'd0, 4'd0, 4'd0, 20'hFFFC0, 10'h000, 20'h8000A, 1'b0);
    vt[5]  = mk(5'd10, 4'd0, 4'd0, 4'd0, 20'hFFFBF, 10'h000, 20'h00000, 1'b1);
    vt[6]  = mk(5'd11, 4'd5, 4'd0, 4'hF, 20'h12345, 10'h3FF, 20'h7FEAB, 1'b0);
    vt[7]  = mk(5'd12, 4'd9, 4'd7, 4'd0, 20'h00000, 10'h155, 20'h2AAEC, 1'b0);
    vt[8]  = mk(5'd13, 4'd1, 4'd2, 4'd3, 20'h80000, 10'h2AB, 20'h0556D, 1'b0);
    vt[9]  = mk(5'd14, 4'd3, 4'hA, 4'd0, 20'h00000, 10'h000, 20'h0014E, 1'b0);
    vt[10] = mk(5'd15, 4'd6, 4'd9, 4'd0, 20'h00000, 10'h3FF, 20'h000CF, 1'b0);
    vt[11] = mk(5'd9,  4'hF, 4'hF, 4'hF, 20'h00000, 10'h000, 20'h1FFE9, 1'b0);
    vt[12] = mk(5'd17, 4'd1, 4'd1, 4'd1, 20'h00000, 10'h000, 20'h00000, 1'b1);
    vt[13] = mk(5'd31, 4'd0, 4'd0, 4'd0, 20'h00000, 10'h000, 20'h00000, 1'b1);
    vt[14] = mk(5'd0,  4'hF, 4'hA, 4'h5, 20'hFFFFF, 10'h3FF, 20'h00000, 1'b0);
    vt[15] = mk(5'd3,  4'd1, 4'd0, 4'd0, 20'h40000, 10'h000, 20'h00023, 1'b0);
    add_v  = vt[0];
    halt_v = vt[14];
    i_v    = vt[1];
    i64_v  = vt[2];
    ill_v  = vt[12];
    ld_v   = vt[6];
    pop_v  = vt[10];

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals();

    for (int i = 0; i < 16; i++) begin
      do_reset();
      do_start(10'd5);
      n0 = nwr;
      send(vt[i]);
      if (vt[i].err) begin
        chk($sformatf("v%0d error", i), error, 1);
        chk($sformatf("v%0d we", i), mem_we, 0);
      end else begin
        chk($sformatf("v%0d we", i), mem_we, 1);
        chk($sformatf("v%0d wdata", i), mem_wdata, vt[i].word);
        chk($sformatf("v%0d waddr", i), mem_addr, 5);
      end
      @(negedge clk);
      chk($sformatf("v%0d writes", i), nwr - n0, vt[i].err ? 0 : 1);
      chk($sformatf("v%0d done", i), done, !vt[i].err && vt[i].op == 0);
    end

    do_reset();
    do_start(10'd0);
    send(add_v);
    send(halt_v);
    @(negedge clk);
    chk("A mem0", mem_m[0], 20'h08641);
    chk("A mem1", mem_m[1], 20'h00000);
    chk("A done", done, 1);
    chk("A count", count, 2);
    chk("A busy", busy, 0);

    do_reset();
    do_start(10'd0);
    send(i_v);
    @(negedge clk);
    chk("B count1", count, 1);
    n0 = nwr;
    send(i64_v);
    chk("B error", error, 1);
    chk("B we", mem_we, 0);
    @(negedge clk);
    chk("B writes", nwr - n0, 0);
    chk("B count", count, 1);

    do_reset();
    do_start(10'd0);
    n0 = nwr;
    send(ill_v);
    chk("C error", error, 1);
    @(negedge clk);
    chk("C writes", nwr - n0, 0);
    do_start(10'd3);
    chk("C error clr", error, 0);
    chk("C busy", busy, 1);
    chk("C ready", in_ready, 1);

    do_reset();
    do_start(10'd1023);
    send(ld_v);
    chk("D we", mem_we, 1);
    chk("D addr", mem_addr, 1023);
    chk("D wdata", mem_wdata, 20'h7FEAB);
    @(negedge clk);
    chk("D overflow", error, 1);
    chk("D done0", done, 0);
    chk("D count", count, 1);
    do_start(10'd1023);
    chk("D restart err", error, 0);
    send(halt_v);
    @(negedge clk);
    chk("D halt done", done, 1);
    chk("D halt error", error, 0);
    chk("D mem1023", mem_m[1023], 20'h00000);

    do_reset();
    do_start(10'd200);
    n0 = nwr;
    set_fields(pop_v);
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("E ready%0d", k), in_ready, (k % 2) == 0);
      chk($sformatf("E we%0d", k), mem_we, k % 2);
      if (k % 2) begin
        chk($sformatf("E addr%0d", k), mem_addr, 200 + k / 2);
        chk($sformatf("E wdata%0d", k), mem_wdata, 20'h000CF);
      end
      if (k == 7) in_valid = 1'b0;
      @(negedge clk);
    end
    chk("E writes", nwr - n0, 4);
    chk("E count", count, 4);

    do_reset();
    do_start(10'd10);
    start = 1'b1;
    base_addr = 10'd20;
    @(negedge clk);
    start = 1'b0;
    chk("F busy", busy, 1);
    chk("F ready", in_ready, 1);
    send(add_v);
    chk("F addr", mem_addr, 10);
    chk("F count", count, 0);
    @(negedge clk);
    set_fields(add_v);
    in_valid = 1'b1;
    n0 = nwr;
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("F rst we", mem_we, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("F rst writes", nwr - n0, 0);
    chk_reset_vals();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Sequential instruction packer and program loader for the 20-bit SuperSpeedCPU instruction memory. It accepts one instruction at a time as separate fields over a valid/ready handshake, checks opcode and field ranges, and packs the fields into the 20-bit word format the control unit's decoder consumes. It then writes the word into instruction memory at an auto-incrementing address. It sits between the test/boot stimulus path and the instruction memory write port, and stops on HALT or error.

## Interface

- No parameters; widths are fixed by the ISA package.

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load at base_addr
- base_addr  in  10  first memory address written
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- in_opcode  in  5  opcode
- in_dr  in  4  destination register
- in_sr1  in  4  source register 1
- in_sr2  in  4  source register 2
- in_imm  in  20  signed immediate (two's complement)
- in_addr  in  10  memory/jump address
- mem_we  out  1  instruction memory write strobe
- mem_addr  out  10  write address
- mem_wdata  out  20  packed instruction
- busy  out  1  load in progress
- done  out  1  HALT written; sticky until start or rst
- error  out  1  load aborted; sticky until start or rst
- count  out  11  words written in current load

## Operation

- Opcode map:
  - 0: HALT
  - 1/3/5/7/9: ALU register form
  - 2/4/6/8/10: ALU immediate form
  - 11: LD
  - 12: ST
  - 13: JUMP
  - 14: PUSH
  - 15: POP
  - 16–31: illegal
- Packing (unlisted bits zero; opcode always [4:0]):
  - R-form: dr[8:5], sr1[12:9], sr2[16:13].
  - I-form: dr[8:5], sr1[12:9], imm[19:13] (7-bit signed, range −64..63).
  - LD: dr[8:5], addr[18:9].
  - ST: sr1[8:5], addr[18:9].
  - JUMP: addr[14:5].
  - PUSH: sr1[8:5].
  - POP: dr[8:5].
  - HALT: all zero.
- Unused input fields are ignored and never cause errors.
- FSM states: IDLE, ACCEPT, WRITE, DONE, ERROR.
  - IDLE: in_ready=0. On start: load address register ← base_addr, count←0, go to ACCEPT.
  - ACCEPT: in_ready=1. On in_valid&&in_ready: if the opcode is illegal or the I-form immediate is out of range, go to ERROR with nothing written. Otherwise latch the packed word and go to WRITE.
  - WRITE: mem_we=1 for exactly one cycle with mem_addr/mem_wdata. Then count+1 and address+1.
    - Word was HALT → DONE.
    - Address was 1023 and word not HALT → ERROR (overflow; the word at 1023 is still written).
    - Otherwise → ACCEPT.
  - DONE/ERROR: outputs held; start restarts as from IDLE and clears done/error.
- start in ACCEPT or WRITE is ignored.
- busy = state ∈ {ACCEPT, WRITE}.
- Address never wraps silently.

## Timing

- Reset values: state IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, count=0.
- rst mid-load aborts immediately; a write in progress in that cycle is suppressed.
- Handshake at edge N → mem_we high in cycle N+1 → in_ready high again in N+2. Maximum throughput is one instruction per 2 cycles.
- in_ready is a registered state decode and does not depend on in_valid.
- done/error assert the cycle after the final WRITE or the rejecting handshake.
- mem_addr/mem_wdata are registered and stable whenever mem_we=1.

## Structure

- Shared package isa_pkg: opcode localparams (OP_HALT … OP_POP), field bit positions, IMM_BITS=7, INSTR_W=20, ADDR_W=10, and an encode function.
- The control unit's decoder imports the same package so both directions share one field definition.
- One combinational sub-module, instruction_packer (fields → word + illegal flag), instantiated by the FSM.

## Test plan

- start, base_addr=0. Send R ADD (op 1, dr 2, sr1 3, sr2 4), then HALT. Expect:
  - mem[0]=0x08641
  - mem[1]=0x00000
  - done=1, count=2
- I-form: op 2, dr 1, sr1 1, imm −1. Expect word 0xFE222. Repeat with imm 64 → error=1, no mem_we, count unchanged.
- Illegal opcode 17 as the first bundle. Expect error=1 the next cycle, zero writes. Then a new start recovers: error=0, busy=1.
- LD dr 5, addr 0x3FF at base_addr=1023. Expect the word written at 1023, then error=1 (overflow). The same sequence ending in HALT at 1023 gives done=1.
- in_valid held high for 4 bundles. Verify in_ready toggles 1,0,1,0, exactly one mem_we per bundle, and consecutive addresses.
- Assert rst during a WRITE cycle. Expect no mem_we that cycle and all outputs at reset values the next cycle. start during ACCEPT has no effect.
